// File: rtl/param_seq_detector.sv
// Serial pattern detector: run-time loadable PAT_W-bit pattern, overlap/non-overlap
// mode, stall enable, zero-latency Mealy match plus registered copy and saturating count.
module param_seq_detector #(
  parameter int                 PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PAT_RST = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             dout,
  output logic             dout_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PAT_W-1:0] pattern
);

  localparam int               FILL_W   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  r_pattern;
  logic              r_dout_q;
  logic [CNT_W-1:0]  r_cnt;

  logic [PAT_W-1:0]  w_window;
  logic              w_match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] v);
    return (v == FILL_MAX) ? FILL_MAX : v + FILL_W'(1);
  endfunction

  // The window is the stored history with the current bit appended as LSB.
  assign w_window = {r_hist, din};
  assign w_match  = rst_n & en & ~pat_load & (r_fill == FILL_MAX) & (w_window == r_pattern);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= PAT_RST;
      r_dout_q  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_dout_q <= w_match;

      if (cnt_clr)
        r_cnt <= '0;
      else if (w_match)
        r_cnt <= sat_inc(r_cnt);

      // A load flushes history so the new pattern never matches against stale bits.
      if (pat_load) begin
        r_pattern <= pat_in;
        r_hist    <= '0;
        r_fill    <= '0;
      end else if (en) begin
        if (w_match && !overlap) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_window[PAT_W-2:0];
          r_fill <= fill_inc(r_fill);
        end
      end
    end
  end

  assign dout      = w_match;
  assign dout_q    = r_dout_q;
  assign match_cnt = r_cnt;
  assign pattern   = r_pattern;

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed bench for param_seq_detector: default build plus a CNT_W=2 build on shared inputs.
module tb_param_seq_detector;

  logic       clk = 1'b0;
  logic       rst_n, en, din, overlap, pat_load, cnt_clr;
  logic [3:0] pat_in;
  logic       dout, dout_q, dout2, dout_q2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  logic [3:0] pattern, pattern2;
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  param_seq_detector u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .dout(dout), .dout_q(dout_q), .match_cnt(match_cnt), .pattern(pattern)
  );

  param_seq_detector #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .dout(dout2), .dout_q(dout_q2), .match_cnt(match_cnt2), .pattern(pattern2)
  );

  // Drive one cycle; dout of both instances sampled at the falling edge.
  task automatic step(input logic e, input logic d, output logic o1, output logic o2);
    en  = e;
    din = d;
    @(negedge clk);
    o1 = dout;
    o2 = dout2;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] p, input logic d, output logic o1);
    logic o2;
    pat_load = 1'b1;
    pat_in   = p;
    step(1'b1, d, o1, o2);
    pat_load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; din = 1'b0; overlap = 1'b0;
    pat_load = 1'b0; pat_in = 4'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; din = 1'b1; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 4'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (dout !== 1'b0) begin nerr++; $display("FAIL rst_dout got %b exp 0", dout); end
    nvec++; if (dout_q !== 1'b0) begin nerr++; $display("FAIL rst_dout_q got %b exp 0", dout_q); end
    nvec++; if (match_cnt !== 8'd0) begin nerr++; $display("FAIL rst_cnt got %0d exp 0", match_cnt); end
    nvec++; if (pattern !== 4'b1011) begin nerr++; $display("FAIL rst_pattern got %b exp 1011", pattern); end
    rst_n = 1'b1;
  endtask

  task automatic test_nonoverlap();
    logic [8:0] s = 9'b001011011;
    logic [8:0] e = 9'b000001000;
    logic o1, o2;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, s[8-i], o1, o2);
      nvec++; if (o1 !== e[8-i]) begin nerr++; $display("FAIL t1_dout[%0d] got %b exp %b", i, o1, e[8-i]); end
    end
    nvec++; if (match_cnt !== 8'd1) begin nerr++; $display("FAIL t1_cnt got %0d exp 1", match_cnt); end
  endtask

  task automatic test_overlap_modes();
    logic [6:0] s  = 7'b1011011;
    logic [6:0] eo = 7'b0001001;
    logic [6:0] en_ = 7'b0001000;
    logic o1, o2;
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s[6-i], o1, o2);
      nvec++; if (o1 !== eo[6-i]) begin nerr++; $display("FAIL t2o_dout[%0d] got %b exp %b", i, o1, eo[6-i]); end
    end
    nvec++; if (match_cnt !== 8'd2) begin nerr++; $display("FAIL t2o_cnt got %0d exp 2", match_cnt); end
    do_reset();
    overlap = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s[6-i], o1, o2);
      nvec++; if (o1 !== en_[6-i]) begin nerr++; $display("FAIL t2n_dout[%0d] got %b exp %b", i, o1, en_[6-i]); end
    end
    nvec++; if (match_cnt !== 8'd1) begin nerr++; $display("FAIL t2n_cnt got %0d exp 1", match_cnt); end
  endtask

  task automatic test_pat_load();
    logic [3:0] s1 = 4'b0110;
    logic [3:0] e1 = 4'b0001;
    logic [3:0] s2 = 4'b1011;
    logic o1, o2;
    do_reset();
    step(1'b1, 1'b1, o1, o2);
    step(1'b1, 1'b0, o1, o2);
    step(1'b1, 1'b1, o1, o2);
    // Window on the load cycle would be 1011, matching the old pattern.
    load(4'b0110, 1'b1, o1);
    nvec++; if (o1 !== 1'b0) begin nerr++; $display("FAIL t3_load_dout got %b exp 0", o1); end
    nvec++; if (pattern !== 4'b0110) begin nerr++; $display("FAIL t3_pattern got %b exp 0110", pattern); end
    nvec++; if (match_cnt !== 8'd0) begin nerr++; $display("FAIL t3_load_cnt got %0d exp 0", match_cnt); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, s1[3-i], o1, o2);
      nvec++; if (o1 !== e1[3-i]) begin nerr++; $display("FAIL t3_dout[%0d] got %b exp %b", i, o1, e1[3-i]); end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, s2[3-i], o1, o2);
      nvec++; if (o1 !== 1'b0) begin nerr++; $display("FAIL t3_old_dout[%0d] got %b exp 0", i, o1); end
    end
    nvec++; if (match_cnt !== 8'd1) begin nerr++; $display("FAIL t3_cnt got %0d exp 1", match_cnt); end
  endtask

  task automatic test_stall();
    logic o1, o2;
    do_reset();
    step(1'b1, 1'b1, o1, o2);
    step(1'b1, 1'b0, o1, o2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i[0] ? 1'b0 : 1'b1, o1, o2);
      nvec++; if (o1 !== 1'b0) begin nerr++; $display("FAIL t4_stall_dout[%0d] got %b exp 0", i, o1); end
    end
    step(1'b1, 1'b1, o1, o2);
    nvec++; if (o1 !== 1'b0) begin nerr++; $display("FAIL t4_dout3 got %b exp 0", o1); end
    step(1'b1, 1'b1, o1, o2);
    nvec++; if (o1 !== 1'b1) begin nerr++; $display("FAIL t4_dout4 got %b exp 1", o1); end
    nvec++; if (match_cnt !== 8'd1) begin nerr++; $display("FAIL t4_cnt got %0d exp 1", match_cnt); end
  endtask

  task automatic test_saturate();
    logic [9:0] e = 10'b0001111111;
    logic o1, o2;
    int m = 0;
    do_reset();
    overlap = 1'b1;
    load(4'b1111, 1'b1, o1);
    nvec++; if (pattern2 !== 4'b1111) begin nerr++; $display("FAIL t5_pattern got %b exp 1111", pattern2); end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, o1, o2);
      m += int'(e[9-i]);
      nvec++; if (o2 !== e[9-i]) begin nerr++; $display("FAIL t5_dout[%0d] got %b exp %b", i, o2, e[9-i]); end
      nvec++; if (dout_q2 !== e[9-i]) begin nerr++; $display("FAIL t5_dout_q[%0d] got %b exp %b", i, dout_q2, e[9-i]); end
      nvec++; if (match_cnt2 !== 2'((m > 3) ? 3 : m)) begin nerr++; $display("FAIL t5_cnt[%0d] got %0d exp %0d", i, match_cnt2, (m > 3) ? 3 : m); end
    end
    cnt_clr = 1'b1;
    step(1'b1, 1'b1, o1, o2);
    cnt_clr = 1'b0;
    nvec++; if (o2 !== 1'b1) begin nerr++; $display("FAIL t5_clr_dout got %b exp 1", o2); end
    nvec++; if (match_cnt2 !== 2'd0) begin nerr++; $display("FAIL t5_clr_cnt got %0d exp 0", match_cnt2); end
    step(1'b1, 1'b1, o1, o2);
    nvec++; if (match_cnt2 !== 2'd1) begin nerr++; $display("FAIL t5_post_clr_cnt got %0d exp 1", match_cnt2); end
  endtask

  task automatic test_async_reset();
    logic [3:0] s1 = 4'b1011;
    logic [3:0] s2 = 4'b1101;
    logic [3:0] e  = 4'b0001;
    logic o1, o2;
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, s1[3-i], o1, o2);
    load(4'b1101, 1'b0, o1);
    for (int i = 0; i < 4; i++) step(1'b1, s2[3-i], o1, o2);
    nvec++; if (match_cnt !== 8'd2) begin nerr++; $display("FAIL t6_pre_cnt got %0d exp 2", match_cnt); end
    nvec++; if (dout_q !== 1'b1) begin nerr++; $display("FAIL t6_pre_dout_q got %b exp 1", dout_q); end
    // Stale history is now 101; a 1 would match 1011 if it survived the reset.
    en = 1'b1; din = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (dout !== 1'b0) begin nerr++; $display("FAIL t6_rst_dout got %b exp 0", dout); end
    nvec++; if (dout_q !== 1'b0) begin nerr++; $display("FAIL t6_rst_dout_q got %b exp 0", dout_q); end
    nvec++; if (match_cnt !== 8'd0) begin nerr++; $display("FAIL t6_rst_cnt got %0d exp 0", match_cnt); end
    nvec++; if (pattern !== 4'b1011) begin nerr++; $display("FAIL t6_rst_pattern got %b exp 1011", pattern); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, s1[3-i], o1, o2);
      nvec++; if (o1 !== e[3-i]) begin nerr++; $display("FAIL t6_dout[%0d] got %b exp %b", i, o1, e[3-i]); end
    end
  endtask

  initial begin
    test_reset();
    test_nonoverlap();
    test_overlap_modes();
    test_pat_load();
    test_stall();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
- Parametrised Mealy serial-pattern detector, the next generation of the fixed 1011 detectors in the FSM exercise set.
- Generalises to a PAT_W-bit pattern that is loadable at run time, with overlap or non-overlap mode selected at run time.
- Adds a stall enable, a registered match pulse and a saturating match counter.
- Sits on a 1-bit serial input stream in front of the framing/control logic.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..16).
- PAT_RST, 4'b1011, pattern loaded at reset, PAT_W bits wide. MSB is the first bit received.
- CNT_W, 8, match counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample enable. din is consumed only when en=1.
- din  input  1  serial data bit.
- overlap  input  1  1=overlapping detection, 0=non-overlapping. Sampled each enabled cycle.
- pat_load  input  1  load pat_in into the pattern register.
- pat_in  input  PAT_W  new pattern, MSB first.
- cnt_clr  input  1  synchronous clear of match_cnt.
- dout  output  1  Mealy match output, combinational from state and din.
- dout_q  output  1  dout registered, one cycle later.
- match_cnt  output  CNT_W  saturating count of matches.
- pattern  output  PAT_W  current pattern register.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - hist=0, fill=0, pattern=PAT_RST, dout_q=0, match_cnt=0.
  - dout=0 while rst_n=0.
- State:
  - hist holds the last PAT_W-1 accepted bits, newest in the LSB.
  - fill counts valid history bits, 0..PAT_W-1, saturating at PAT_W-1.
- Match (combinational):
  - dout = rst_n & en & ~pat_load & (fill==PAT_W-1) & ({hist,din}==pattern).
  - Zero latency: dout is high in the same cycle as the last pattern bit.
- Enabled cycle (en=1, pat_load=0) at the clock edge:
  - If dout=1 and overlap=0: hist<=0, fill<=0. The match bits are consumed.
  - Otherwise: hist<={hist[PAT_W-3:0],din}, fill<=min(fill+1,PAT_W-1).
  - For PAT_W=2, hist is the single bit din.
- Stalled cycle (en=0): hist and fill hold. dout=0. Counter is unaffected by matches.
- pat_load=1 (takes priority over en):
  - pattern<=pat_in, hist<=0, fill<=0.
  - din is ignored that cycle and dout=0.
  - The first match is possible PAT_W enabled cycles after the load.
- Mode change: overlap changes take effect on the next match. History is not flushed.
- dout_q <= dout every cycle.
- match_cnt:
  - cnt_clr=1 gives 0. Clear wins over a same-cycle match.
  - Else if dout=1 and match_cnt != all-ones: match_cnt+1.
  - Saturates at 2^CNT_W-1 and never wraps.
- Reset mid-stream: all state is cleared immediately. The pattern reverts to PAT_RST, not to the last loaded value.
- All-zeros or all-ones patterns are legal. In overlap mode they match on every cycle once fill is full.

Test Plan:
1. Reset, overlap=0, en=1, din stream 0,0,1,0,1,1,0,1,1 with default 1011 -> dout=1 only on the 6th bit, match_cnt=1.
2. Same 1011 pattern, overlap=1, stream 1,0,1,1,0,1,1 -> dout=1 on bits 4 and 7, match_cnt=2. With overlap=0 -> only bit 4, match_cnt=1.
3. pat_load with pat_in=4'b0110 mid-stream, then stream 0,1,1,0 -> no match on the load cycle, dout=1 on the 4th post-load bit. A 1011 stream gives no match.
4. Stream 1,0, then en=0 for 3 cycles with din toggling, then en=1 with 1,1 -> dout=1 on the final bit. dout stays 0 while stalled.
5. CNT_W=2 build, overlap=1, pattern 1111, din=1 held for 10 enabled cycles -> match_cnt saturates at 3. Asserting cnt_clr on a match cycle gives match_cnt=0. dout_q trails dout by exactly 1 cycle.
6. Assert rst_n=0 asynchronously between edges after fill=3 and after loading a non-default pattern -> outputs go to 0 immediately and pattern reads 4'b1011. After release, a match needs 4 fresh bits.
